// File: rtl/morse_char_scheduler.sv
// Morse character scheduler: filters PS/2 set-2 scan codes, buffers the
// mapped characters in a FIFO and, on Enter, hands them one at a time to
// the Morse encoder over a start/busy handshake. F1-F4 select encoder speed.
module morse_char_scheduler #(
    parameter int         DEPTH     = 16,
    parameter logic [1:0] SPEED_RST = 2'd1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              scan_code,
    input  logic                    scan_valid,
    input  logic                    enc_busy,
    output logic [5:0]              enc_char,
    output logic                    enc_start,
    output logic [1:0]              speed_sel,
    output logic                    playing,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t         state_q;
    logic           brk_q;
    logic           ext_q;
    logic           playReq_q;
    logic           busy_q;
    logic           overflow_q;
    logic           encStart_q;
    logic           playing_q;
    logic [5:0]     encChar_q;
    logic [1:0]     speed_q;
    logic [AW-1:0]  head_q;
    logic [AW-1:0]  head_d;
    logic [AW-1:0]  tail_q;
    logic [AW-1:0]  tail_d;
    logic [AW:0]    count_q;
    logic [AW:0]    count_d;
    logic [5:0]     mem_q [DEPTH];

    logic           accept;
    logic [6:0]     mapped;
    logic           isChar;
    logic           isEnter;
    logic           isBsp;
    logic           isSpeed;
    logic [1:0]     speedCode;
    logic           doPush;
    logic           doPop;
    logic           doBsp;
    logic           haveNext;

    // Returns {valid, char code} for printable make codes.
    function automatic logic [6:0] mapCode(input logic [7:0] code);
        logic [6:0] r;
        r = '0;
        case (code)
            8'h29: r = {1'b1, 6'd0};
            8'h1C: r = {1'b1, 6'd1};
            8'h32: r = {1'b1, 6'd2};
            8'h21: r = {1'b1, 6'd3};
            8'h23: r = {1'b1, 6'd4};
            8'h24: r = {1'b1, 6'd5};
            8'h2B: r = {1'b1, 6'd6};
            8'h34: r = {1'b1, 6'd7};
            8'h33: r = {1'b1, 6'd8};
            8'h43: r = {1'b1, 6'd9};
            8'h3B: r = {1'b1, 6'd10};
            8'h42: r = {1'b1, 6'd11};
            8'h4B: r = {1'b1, 6'd12};
            8'h3A: r = {1'b1, 6'd13};
            8'h31: r = {1'b1, 6'd14};
            8'h44: r = {1'b1, 6'd15};
            8'h4D: r = {1'b1, 6'd16};
            8'h15: r = {1'b1, 6'd17};
            8'h2D: r = {1'b1, 6'd18};
            8'h1B: r = {1'b1, 6'd19};
            8'h2C: r = {1'b1, 6'd20};
            8'h3C: r = {1'b1, 6'd21};
            8'h2A: r = {1'b1, 6'd22};
            8'h1D: r = {1'b1, 6'd23};
            8'h22: r = {1'b1, 6'd24};
            8'h35: r = {1'b1, 6'd25};
            8'h1A: r = {1'b1, 6'd26};
            8'h45: r = {1'b1, 6'd27};
            8'h16: r = {1'b1, 6'd28};
            8'h1E: r = {1'b1, 6'd29};
            8'h26: r = {1'b1, 6'd30};
            8'h25: r = {1'b1, 6'd31};
            8'h2E: r = {1'b1, 6'd32};
            8'h36: r = {1'b1, 6'd33};
            8'h3D: r = {1'b1, 6'd34};
            8'h3E: r = {1'b1, 6'd35};
            8'h46: r = {1'b1, 6'd36};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Decode the current byte and resolve same-cycle push/pop/backspace.
    always_comb begin
        accept    = scan_valid && !brk_q && !ext_q &&
                    (scan_code != 8'hF0) && (scan_code != 8'hE0);
        mapped    = mapCode(scan_code);
        isChar    = accept && mapped[6];
        isEnter   = accept && (scan_code == 8'h5A);
        isBsp     = accept && (scan_code == 8'h66);
        isSpeed   = 1'b0;
        speedCode = 2'd0;
        case (scan_code)
            8'h05: begin isSpeed = accept; speedCode = 2'd0; end
            8'h06: begin isSpeed = accept; speedCode = 2'd1; end
            8'h04: begin isSpeed = accept; speedCode = 2'd2; end
            8'h0C: begin isSpeed = accept; speedCode = 2'd3; end
            default: begin isSpeed = 1'b0; speedCode = 2'd0; end
        endcase
        doPop    = (state_q == ISSUE) && (count_q != '0);
        doPush   = isChar && ((count_q != FULL) || doPop);
        doBsp    = isBsp && (count_q != '0) && !(doPop && (count_q == ONE));
        haveNext = (count_q != '0) && !((count_q == ONE) && doBsp);
        head_d   = head_q + AW'(doPop);
        tail_d   = tail_q + AW'(doPush) - AW'(doBsp);
        count_d  = count_q + (AW+1)'(doPush) - (AW+1)'(doPop) - (AW+1)'(doBsp);
    end

    // Prefix flags, FIFO pointers, speed select, overflow pulse and busy sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            speed_q    <= SPEED_RST;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (scan_valid) begin
                if (brk_q || ext_q) begin
                    brk_q <= ext_q && (scan_code == 8'hF0);
                    ext_q <= 1'b0;
                end else if (scan_code == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (scan_code == 8'hE0) begin
                    ext_q <= 1'b1;
                end
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (isSpeed) begin
                speed_q <= speedCode;
            end
            overflow_q <= isChar && (count_q == FULL) && !doPop;
            busy_q     <= enc_busy;
        end
    end

    // Character storage; holds no state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[tail_q] <= mapped[5:0];
        end
    end

    // Playback FSM issuing one character per encoder busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            playReq_q  <= 1'b0;
            playing_q  <= 1'b0;
            encStart_q <= 1'b0;
            encChar_q  <= '0;
        end else begin
            encStart_q <= 1'b0;
            if (isEnter && (count_q != '0) && !playing_q) begin
                playReq_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (playReq_q) begin
                        if (haveNext) begin
                            state_q    <= ISSUE;
                            encStart_q <= 1'b1;
                            encChar_q  <= mem_q[head_q];
                            playing_q  <= 1'b1;
                        end else begin
                            playReq_q <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (busy_q) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!busy_q) begin
                        if (haveNext) begin
                            state_q    <= ISSUE;
                            encStart_q <= 1'b1;
                            encChar_q  <= mem_q[head_q];
                        end else begin
                            state_q   <= IDLE;
                            playing_q <= 1'b0;
                            playReq_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign enc_char   = encChar_q;
    assign enc_start  = encStart_q;
    assign speed_sel  = speed_q;
    assign playing    = playing_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_char_scheduler.sv
// Testbench for morse_char_scheduler: table of single-byte vectors for the
// filter/map/speed paths plus hand-written playback sequences driven against
// a simple encoder model that holds busy for 20 cycles per start.
module tb_morse_char_scheduler;

    localparam int DEPTH = 16;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] scan_code  = 8'h00;
    logic       scan_valid = 1'b0;
    logic       enc_busy;
    logic       modelEn    = 1'b1;
    logic       modelBusy  = 1'b0;
    logic       manualBusy = 1'b0;
    logic [5:0] enc_char;
    logic       enc_start;
    logic [1:0] speed_sel;
    logic       playing;
    logic [4:0] fifo_count;
    logic       overflow;

    int checks      = 0;
    int errors      = 0;
    int startLog[$];
    int expQ[$];
    int overflowCnt = 0;
    int cyc         = 0;
    int busyCnt     = 0;
    bit fallPending = 1'b0;
    int fallCyc     = 0;

    typedef struct {
        logic [7:0] code;
        int         expCount;
        int         expSpeed;
    } vec_t;

    vec_t vecs[20];

    assign enc_busy = modelEn ? modelBusy : manualBusy;

    morse_char_scheduler #(.DEPTH(DEPTH), .SPEED_RST(2'd1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .enc_busy   (enc_busy),
        .enc_char   (enc_char),
        .enc_start  (enc_start),
        .speed_sel  (speed_sel),
        .playing    (playing),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Encoder model: logs each start, holds busy 20 cycles, checks restart latency.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (overflow) overflowCnt = overflowCnt + 1;
        if (!playing) fallPending = 1'b0;
        if (enc_start) begin
            startLog.push_back(int'(enc_char));
            if (fallPending) begin
                checkOutput("busyFallToStart", cyc - fallCyc, 2);
                fallPending = 1'b0;
            end
        end
        if (!rst_n) begin
            busyCnt   = 0;
            modelBusy = 1'b0;
        end else if (enc_start && busyCnt == 0) begin
            busyCnt   = 20;
            modelBusy = 1'b1;
        end else if (busyCnt > 0) begin
            busyCnt = busyCnt - 1;
            if (busyCnt == 0) begin
                modelBusy   = 1'b0;
                fallPending = 1'b1;
                fallCyc     = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clk);
        scan_code  = code;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        modelEn    = 1'b1;
        manualBusy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        startLog.delete();
        expQ.delete();
        overflowCnt = 0;
        @(negedge clk);
    endtask

    task automatic finishPlayback(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!playing) break;
            @(negedge clk);
        end
        checkOutput({name, "_playFall"}, int'(playing), 0);
        checkOutput({name, "_starts"}, startLog.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_char%0d", name, i),
                        (i < startLog.size()) ? startLog[i] : -1, expQ[i]);
        end
        checkOutput({name, "_count"}, int'(fifo_count), 0);
    endtask

    task automatic playAndCheck(input string name, input int budget);
        bit rose;
        rose = 1'b0;
        applyStimulus(8'h5A);
        for (int i = 0; i < 8; i++) begin
            if (playing) begin
                rose = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, "_playRise"}, int'(rose), 1);
        finishPlayback(name, budget);
    endtask

    task automatic waitFirstStart(input string name);
        for (int i = 0; i < 10; i++) begin
            if (startLog.size() > 0) break;
            @(negedge clk);
        end
        checkOutput({name, "_firstStart"}, startLog.size(), 1);
    endtask

    initial begin
        logic [7:0] aToQ [17];
        bit sawStart;
        bit sawPlay;

        vecs[0]  = '{8'h1C, 1, 1};
        vecs[1]  = '{8'hF0, 1, 1};
        vecs[2]  = '{8'h1C, 1, 1};
        vecs[3]  = '{8'hE0, 1, 1};
        vecs[4]  = '{8'h75, 1, 1};
        vecs[5]  = '{8'hE0, 1, 1};
        vecs[6]  = '{8'hF0, 1, 1};
        vecs[7]  = '{8'h75, 1, 1};
        vecs[8]  = '{8'h21, 2, 1};
        vecs[9]  = '{8'h29, 3, 1};
        vecs[10] = '{8'h45, 4, 1};
        vecs[11] = '{8'h46, 5, 1};
        vecs[12] = '{8'h76, 5, 1};
        vecs[13] = '{8'h66, 4, 1};
        vecs[14] = '{8'h05, 4, 0};
        vecs[15] = '{8'h0C, 4, 3};
        vecs[16] = '{8'hF0, 4, 3};
        vecs[17] = '{8'h05, 4, 3};
        vecs[18] = '{8'h04, 4, 2};
        vecs[19] = '{8'h06, 4, 1};

        aToQ = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};

        $display("[TB] reset state");
        doReset();
        checkOutput("rst_encChar", int'(enc_char), 0);
        checkOutput("rst_encStart", int'(enc_start), 0);
        checkOutput("rst_playing", int'(playing), 0);
        checkOutput("rst_count", int'(fifo_count), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_speed", int'(speed_sel), 1);

        $display("[TB] basic playback with Enter latency");
        applyStimulus(8'h1C);
        applyStimulus(8'h29);
        applyStimulus(8'h32);
        checkOutput("t1_countBefore", int'(fifo_count), 3);
        applyStimulus(8'h5A);
        checkOutput("t1_startAtN1", int'(enc_start), 0);
        @(negedge clk);
        checkOutput("t1_startAtN2", int'(enc_start), 1);
        checkOutput("t1_playingAtN2", int'(playing), 1);
        expQ = '{1, 0, 2};
        finishPlayback("t1", 400);

        $display("[TB] filter, map and speed table");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].code);
            checkOutput($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].expCount);
            checkOutput($sformatf("vec%0d_speed", i), int'(speed_sel), vecs[i].expSpeed);
            checkOutput($sformatf("vec%0d_overflow", i), int'(overflow), 0);
        end
        expQ = '{1, 3, 0, 27};
        playAndCheck("t2", 400);

        $display("[TB] full FIFO and overflow");
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(aToQ[i]);
        checkOutput("t3_countFull", int'(fifo_count), 16);
        checkOutput("t3_noOverflowYet", int'(overflow), 0);
        applyStimulus(aToQ[16]);
        checkOutput("t3_overflowPulse", int'(overflow), 1);
        checkOutput("t3_countStill16", int'(fifo_count), 16);
        @(negedge clk);
        checkOutput("t3_overflowOneCycle", int'(overflow), 0);
        checkOutput("t3_overflowCnt", overflowCnt, 1);
        for (int i = 1; i <= 16; i++) expQ.push_back(i);
        playAndCheck("t3", 1000);

        $display("[TB] backspace and Enter on empty buffer");
        doReset();
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h66);
        checkOutput("t4_countAfterBsp", int'(fifo_count), 1);
        expQ = '{2};
        playAndCheck("t4", 200);
        applyStimulus(8'h5A);
        sawStart = 1'b0;
        sawPlay  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sawStart |= enc_start;
            sawPlay  |= playing;
            @(negedge clk);
        end
        checkOutput("t4_emptyNoStart", int'(sawStart), 0);
        checkOutput("t4_emptyNoPlay", int'(sawPlay), 0);
        checkOutput("t4_startTotal", startLog.size(), 1);

        $display("[TB] speed change and typing during playback");
        doReset();
        applyStimulus(8'h1C);
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h23);
        applyStimulus(8'h24);
        applyStimulus(8'h5A);
        waitFirstStart("t5");
        applyStimulus(8'h0C);
        checkOutput("t5_speedMidPlay", int'(speed_sel), 3);
        applyStimulus(8'h1C);
        expQ = '{1, 2, 3, 4, 5, 1};
        finishPlayback("t5", 600);
        doReset();
        checkOutput("t5_speedAfterReset", int'(speed_sel), 1);
        applyStimulus(8'h05);
        checkOutput("t5_speedF1", int'(speed_sel), 0);

        $display("[TB] reset during playback");
        doReset();
        applyStimulus(8'h1C);
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h23);
        applyStimulus(8'h5A);
        waitFirstStart("t6");
        repeat (5) @(negedge clk);
        checkOutput("t6_countInWait", int'(fifo_count), 3);
        checkOutput("t6_charInWait", int'(enc_char), 1);
        checkOutput("t6_playingInWait", int'(playing), 1);
        #2;
        rst_n   = 1'b0;
        modelEn = 1'b0;
        #1;
        checkOutput("t6_asyncEncChar", int'(enc_char), 0);
        checkOutput("t6_asyncEncStart", int'(enc_start), 0);
        checkOutput("t6_asyncPlaying", int'(playing), 0);
        checkOutput("t6_asyncCount", int'(fifo_count), 0);
        checkOutput("t6_asyncOverflow", int'(overflow), 0);
        checkOutput("t6_asyncSpeed", int'(speed_sel), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        startLog.delete();
        sawStart = 1'b0;
        sawPlay  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((i % 4) == 0) manualBusy = ~manualBusy;
            sawStart |= enc_start;
            sawPlay  |= playing;
        end
        checkOutput("t6_noStartAfterReset", startLog.size(), 0);
        checkOutput("t6_noStartSeen", int'(sawStart), 0);
        checkOutput("t6_noPlayAfterReset", int'(sawPlay), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_char_scheduler.md
Name: morse_char_scheduler

Overview:
- Sits between the PS/2 controller and the Morse code encoder.
- Filters set-2 scan codes (drops break and extended sequences) and maps make codes to character codes.
- Buffers typed characters in a FIFO.
- On Enter, feeds the characters one at a time to the encoder using a start/busy handshake.
- Also configures encoder speed from the F1–F4 keys.

Parameters:
DEPTH, 16, FIFO entries (power of 2, ≥2)
SPEED_RST, 2'd1, speed_sel value after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_code  in  8  received scan code byte, valid when scan_valid=1
scan_valid  in  1  one-cycle strobe from PS/2 controller
enc_busy  in  1  high while encoder is emitting a character/gap
enc_char  out  6  character code presented to encoder
enc_start  out  1  one-cycle start pulse to encoder
speed_sel  out  2  encoder speed select
playing  out  1  high while playback active
fifo_count  out  $clog2(DEPTH)+1  buffered entries
overflow  out  1  one-cycle pulse when a character is dropped because the FIFO is full

Behaviour:
- Reset (async, rst_n=0): FIFO empty; ptrs=0; flags cleared; FSM=IDLE. Outputs: enc_char=0, enc_start=0, playing=0, fifo_count=0, overflow=0, speed_sel=SPEED_RST.
- Input filter (evaluated only on scan_valid):
  - F0: set brk flag. The next byte is discarded and the flag cleared.
  - E0: set ext flag. The next byte is discarded (including a following F0, which also sets brk so the trailing byte is discarded).
  - Byte after a set brk/ext flag: no effect other than clearing the flag.
- Character map (char codes):
  - Space 29 -> 0.
  - A–Z 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 1..26.
  - Digits 0–9 45,16,1E,26,25,2E,36,3D,3E,46 -> 27..36.
  - Any other code not listed in this section: ignored.
- Mapped code: pushed to FIFO tail if count<DEPTH. Otherwise dropped, and overflow pulses 1 cycle, registered.
- Control keys:
  - Enter 5A: sets play_req if count>0; ignored if count=0 or already playing.
  - Backspace 66: removes the tail entry if count>0.
  - F1 05 -> speed_sel=0; F2 06 -> 1; F3 04 -> 2; F4 0C -> 3. Takes effect next cycle, including mid-playback.
- Keys, pushes and Backspace are accepted in every FSM state.
- FSM:
  - IDLE: if play_req and count>0 -> ISSUE; playing=1.
  - ISSUE (1 cycle): enc_char<=head; enc_start=1; pop head -> WAIT_ACK.
  - WAIT_ACK: on enc_busy=1 -> WAIT_DONE. No timeout.
  - WAIT_DONE: on enc_busy=0: if count>0 -> ISSUE; else -> IDLE, clearing playing and play_req.
- Characters typed during playback are played in the same run.
- enc_char holds its value until the next ISSUE.
- Latency: Enter strobe at cycle N -> enc_start high at cycle N+2. Encoder busy fall at cycle M -> next enc_start at M+2.
- Simultaneous events:
  - Push and pop in the same cycle: both apply; count unchanged.
  - Pop and Backspace in the same cycle with count=1: pop wins; Backspace ignored.
  - Pop and Backspace with count≥2: both apply.
  - Push at count=DEPTH with a concurrent pop: push accepted, no overflow.
- Pointers wrap modulo DEPTH; fifo_count is exact over 0..DEPTH.
- Reset mid-playback: enc_start drops immediately and the buffer is lost. The encoder is reset by the same rst_n.

Test Plan:
1. Reset, then strobes 1C,29,32,5A; encoder model holds busy 20 cycles after each start -> enc_char sequence 1,0,2; exactly 3 enc_start pulses; playing falls after the 3rd busy fall; fifo_count=0.
2. Strobes 1C, F0,1C, E0,75, E0,F0,75, 21 -> fifo_count=2; playback after 5A yields enc_char 1 then 3.
3. Push 17 mapped codes with DEPTH=16 -> fifo_count=16; one overflow pulse on the 17th; playback yields the first 16 in order.
4. Strobes 32,21,66,5A -> only enc_char=2 issued. Then 5A with empty FIFO -> no enc_start, playing stays 0.
5. During playback of 5 chars, strobe 0C then 1C -> speed_sel=3 next cycle; 6 starts total, last enc_char=1. 05 after reset -> speed_sel=0.
6. Assert rst_n=0 in WAIT_DONE with count=3 -> all outputs at reset values asynchronously; after release, enc_busy toggling produces no enc_start.
